// File: rtl/aes_inv_cipher_ctrl.sv
// AES-256 inverse cipher, one round per clock.
// The round key is fetched combinationally through keyIdx.
module aes_inv_cipher_ctrl #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic [127:0] inData,
  input  logic         inValid,
  output logic         inReady,
  output logic [3:0]   keyIdx,
  input  logic [127:0] roundKey,
  output logic [127:0] outData,
  output logic         outValid,
  input  logic         outReady,
  output logic         busy
);

  localparam logic [3:0] LP_NR = 4'(NR);

  // Inverse S-box; element 255 holds the entry for input 0x00.
  localparam logic [255:0][7:0] LP_ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_rnd;
  logic [3:0]   w_rnd_nxt;
  logic [127:0] r_st;
  logic [127:0] w_st_nxt;

  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  function automatic logic [7:0] f_xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k using shift-and-xor.
  function automatic logic [7:0] f_gm(
    input logic [7:0] b,
    input logic [3:0] k
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = b;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ x;
      x = f_xt(x);
    end
    return p;
  endfunction

  // Row r is rotated right by r byte positions.
  function automatic logic [127:0] f_inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] f_inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = LP_ISBOX[~s[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [31:0] f_inv_mix_col(
    input logic [31:0] a
  );
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {
      f_gm(a0, 4'he) ^ f_gm(a1, 4'hb) ^
      f_gm(a2, 4'hd) ^ f_gm(a3, 4'h9),
      f_gm(a0, 4'h9) ^ f_gm(a1, 4'he) ^
      f_gm(a2, 4'hb) ^ f_gm(a3, 4'hd),
      f_gm(a0, 4'hd) ^ f_gm(a1, 4'h9) ^
      f_gm(a2, 4'he) ^ f_gm(a3, 4'hb),
      f_gm(a0, 4'hb) ^ f_gm(a1, 4'hd) ^
      f_gm(a2, 4'h9) ^ f_gm(a3, 4'he)
    };
  endfunction

  function automatic logic [127:0] f_inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = f_inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign w_isr = f_inv_shift_rows(r_st);
  assign w_isb = f_inv_sub_bytes(w_isr);
  assign w_ark = w_isb ^ roundKey;
  assign w_imc = f_inv_mix_columns(w_ark);

  assign inReady  = (r_state == S_IDLE);
  assign busy     = (r_state == S_ROUND) ||
                    (r_state == S_FINAL);
  assign outValid = (r_state == S_DONE);
  assign outData  = r_st;

  // Key index follows the round counter while rounds run.
  always_comb begin
    keyIdx = LP_NR;
    case (r_state)
      S_ROUND: keyIdx = r_rnd;
      S_FINAL: keyIdx = r_rnd;
      S_DONE:  keyIdx = 4'd0;
      default: keyIdx = LP_NR;
    endcase
  end

  // Next state, round counter and block state.
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_st_nxt    = r_st;
    case (r_state)
      S_IDLE: begin
        if (inValid) begin
          w_st_nxt    = inData ^ roundKey;
          w_rnd_nxt   = LP_NR - 4'd1;
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        w_st_nxt  = w_imc;
        w_rnd_nxt = (r_rnd == 4'd0) ? 4'd0 : r_rnd - 4'd1;
        if (r_rnd <= 4'd1) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_st_nxt    = w_ark;
        w_rnd_nxt   = 4'd0;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (outReady) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rnd_nxt   = 4'd0;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_rnd   <= 4'd0;
      r_st    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_st    <= w_st_nxt;
    end
  end

endmodule
